mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Memory-side responder for the pipeline's two memory initiators: I-side (fetch) and D-side (load/store).
//  Answers each request with a one-cycle resp pulse; the hazard unit stalls the pipeline until that pulse.
//  Serialises both initiators onto one shared downstream memory port, using the same read/write/resp handshake.
//  Sits between the IF/MEM pipeline stages and the cache/physical memory.
// PARAMETERS
//  ADDR_W   32  address width, all ports
//  DATA_W   32  data width, all ports; byte-enable width = DATA_W/8
//  RR_TIE    1  1: round-robin on simultaneous I/D requests; 0: D-side always wins ties
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         reset, asynchronous, active-low
//  inst_mem_read  in   1         I-side read request, held until inst_mem_resp
//  inst_mem_addr  in   ADDR_W    I-side address
//  inst_mem_rdata out  DATA_W    I-side read data, valid only when inst_mem_resp=1
//  inst_mem_resp  out  1         I-side completion pulse
//  data_mem_read  in   1         D-side read request, held until data_mem_resp
//  data_mem_write in   1         D-side write request, held until data_mem_resp
//  data_mem_addr  in   ADDR_W    D-side address
//  data_mem_wdata in   DATA_W    D-side write data
//  data_mem_mbe   in   DATA_W/8  D-side byte enables (write only)
//  data_mem_rdata out  DATA_W    D-side read data, valid only when data_mem_resp=1
//  data_mem_resp  out  1         D-side completion pulse
//  mem_read       out  1         downstream read request
//  mem_write      out  1         downstream write request
//  mem_addr       out  ADDR_W    downstream address (registered)
//  mem_wdata      out  DATA_W    downstream write data (registered)
//  mem_mbe        out  DATA_W/8  downstream byte enables (registered)
//  mem_rdata      in   DATA_W    downstream read data, valid with mem_resp
//  mem_resp       in   1         downstream completion pulse
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, last_grant=I. All outputs 0, including addr/wdata/mbe registers.
//  FSM states: IDLE, I_BUSY, D_BUSY.
//  IDLE:
//   - Arbitrate: D wants = data_mem_read|data_mem_write; I wants = inst_mem_read.
//   - Only one wants -> grant it.
//   - Both want -> RR_TIE=1: grant the side opposite last_grant; RR_TIE=0: grant D.
//   - On grant, register addr/wdata/mbe/op; set last_grant; go to I_BUSY or D_BUSY.
//   - For an I grant, mem_wdata and mem_mbe register 0.
//   - No resp is ever issued from IDLE.
//  X_BUSY:
//   - mem_read/mem_write are driven from the registered op and held until mem_resp.
//   - On mem_resp: the granted side's resp=1 in the same cycle, rdata=mem_rdata (combinational pass-through); next state IDLE.
//   - The other side's resp stays 0 and its rdata is 0.
//  Min latency: request seen in cycle N -> downstream request in N+1 -> resp no earlier than N+1.
//  No back-to-back grants: one IDLE cycle always separates transactions. A request seen in IDLE after a resp is treated as new.
//  Requests from the non-granted side are ignored while busy; they stay pending because initiators hold them.
//  data_mem_read & data_mem_write both high is illegal: assertion fires; write takes precedence.
//  Initiator inputs may change while busy; downstream uses only the registered copies.
//  mem_resp while IDLE is ignored (assertion fires).
//  Reset mid-transaction aborts: no resp is issued; downstream request drops immediately.
// STRUCTURE
//  Shared package rv32i_types gains: typedef enum {IDLE, I_BUSY, D_BUSY} arb_state_t; typedef enum logic {GRANT_I, GRANT_D} arb_grant_t.
//  One natural sub-module: arb_pick.
//   - Combinational tie-break.
//   - Inputs: i_req, d_req, last_grant, RR_TIE.
//   - Outputs: grant_valid, grant.
//  The FSM and datapath registers live in mem_port_arbiter.
// TESTING
//  1 Reset: hold rst=0 with all requests high -> all outputs 0; release -> first grant occurs the next cycle.
//  2 Lone I read: addr 0x60 at cycle 0 -> cycle 1 mem_read=1, mem_addr=0x60.
//    Memory resp at cycle 3 with 0xDEADBEEF -> inst_mem_resp=1 and inst_mem_rdata=0xDEADBEEF at cycle 3; mem_read=0 at cycle 4.
//  3 Lone D write: addr 0x100, wdata 0x12345678, mbe 4'b0011 -> downstream sees exactly those values with mem_write=1.
//    Only data_mem_resp pulses, for one cycle.
//  4 Simultaneous I and D, RR_TIE=1, both held after each resp -> grant order D, I, D, I (last_grant=I at reset); RR_TIE=0 -> D, D, D.
//  5 D request arrives during I_BUSY -> not granted until I's resp; granted in the following IDLE cycle.
//    The D-side address changing mid-I transaction does not alter mem_addr.
//  6 Async reset asserted mid D_BUSY -> mem_write drops within the same cycle; no data_mem_resp.
//    A mem_resp arriving after reset release is ignored in IDLE.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared pipeline types: arbitration state and grant encodings used by the
// memory port arbiter and its tie-break helper.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } arb_grant_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational tie-break between the fetch (I) and load/store (D) initiators.
// Round-robin against last_grant when RR_TIE=1, otherwise D always wins ties.
module arb_pick
   import rv32i_types::*;
#(
   parameter bit RR_TIE = 1'b1
) (
   input  logic       i_req,
   input  logic       d_req,
   input  arb_grant_t last_grant,
   output logic       grant_valid,
   output arb_grant_t grant
);

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_valid = i_req | d_req;
      grant       = GRANT_D;
      if (i_req && !d_req) begin
         grant = GRANT_I;
      end else if (i_req && d_req && RR_TIE && (last_grant == GRANT_D)) begin
         grant = GRANT_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the I-side and D-side memory initiators onto one downstream
// read/write/resp port; one transaction in flight, one IDLE cycle between grants.
module mem_port_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter bit          RR_TIE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_mem_read,
   input  logic [ADDR_W-1:0]     inst_mem_addr,
   output logic [DATA_W-1:0]     inst_mem_rdata,
   output logic                  inst_mem_resp,
   input  logic                  data_mem_read,
   input  logic                  data_mem_write,
   input  logic [ADDR_W-1:0]     data_mem_addr,
   input  logic [DATA_W-1:0]     data_mem_wdata,
   input  logic [DATA_W/8-1:0]   data_mem_mbe,
   output logic [DATA_W-1:0]     data_mem_rdata,
   output logic                  data_mem_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_mbe,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_resp
);

   arb_state_t state, state_next;
   arb_grant_t last_grant;
   arb_grant_t grant;
   logic       grant_valid;
   logic       op_write;
   logic       d_req;

   assign d_req = data_mem_read | data_mem_write;

   arb_pick #(
      .RR_TIE(RR_TIE)
   ) u_pick (
      .i_req      (inst_mem_read),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant_valid(grant_valid),
      .grant      (grant)
   );

   // Downstream request comes from state, so an async reset drops it at once.
   always_comb begin
      state_next     = state;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      inst_mem_resp  = 1'b0;
      data_mem_resp  = 1'b0;
      inst_mem_rdata = '0;
      data_mem_rdata = '0;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               state_next = (grant == GRANT_D) ? D_BUSY : I_BUSY;
            end
         end
         I_BUSY: begin
            mem_read  = ~op_write;
            mem_write = op_write;
            if (mem_resp) begin
               inst_mem_resp  = 1'b1;
               inst_mem_rdata = mem_rdata;
               state_next     = IDLE;
            end
         end
         D_BUSY: begin
            mem_read  = ~op_write;
            mem_write = op_write;
            if (mem_resp) begin
               data_mem_resp  = 1'b1;
               data_mem_rdata = mem_rdata;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
         op_write   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_mbe    <= '0;
      end else begin
         state <= state_next;
         if ((state == IDLE) && grant_valid) begin
            last_grant <= grant;
            if (grant == GRANT_D) begin
               // Write wins when both D-side strobes are (illegally) high.
               op_write  <= data_mem_write;
               mem_addr  <= data_mem_addr;
               mem_wdata <= data_mem_wdata;
               mem_mbe   <= data_mem_mbe;
            end else begin
               op_write  <= 1'b0;
               mem_addr  <= inst_mem_addr;
               mem_wdata <= '0;
               mem_mbe   <= '0;
            end
         end
      end
   end

   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
      !(data_mem_read && data_mem_write))
      else $warning("data_mem_read and data_mem_write both high; write takes precedence");

   a_no_resp_idle: assert property (@(posedge clk) disable iff (!rst)
      !((state == IDLE) && mem_resp))
      else $warning("mem_resp seen while idle; ignored");

endmodule
